// File: rtl/p3p_pkg.sv
// Shared types and constants for the SRAM sharing path: sample word type,
// default SRAM address width and the arbiter state encoding.
package p3p_pkg;

    typedef logic signed [15:0] num;

    localparam int unsigned SRAM_AW = 21;
    localparam int unsigned NUM_W   = 16;

    localparam int unsigned ARB_SW = 2;
    typedef logic [ARB_SW-1:0] arb_state_t;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from ptr+1 (mod N) upward and
// returns the first active request as a one-hot grant plus its index.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_c,
    output logic [PW-1:0] idx_c,
    output logic          any_c
);

    logic [PW-1:0] cand;

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = PW'((32'(ptr) + k) % N);
            if (!any_c && req[cand]) begin
                any_c       = 1'b1;
                idx_c       = cand;
                gnt_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single SRAM controller port among NUM_REQ requesters with a
// round-robin grant, one access in flight, and an optional bounded burst lock.
module sram_arbiter
    import p3p_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned AW        = SRAM_AW,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_we,
    input  logic [NUM_REQ-1:0]       req_lock,
    input  logic [NUM_REQ*AW-1:0]    req_addr,
    input  logic [NUM_REQ*NUM_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output num                       rdata,
    input  logic                     sram_ready,
    input  logic                     sram_done,
    input  num                       sram_rdata,
    output logic [AW-1:0]            sram_addr,
    output num                       sram_wdata,
    output logic                     sram_read,
    output logic                     sram_write
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_t          state, state_nxt;
    logic [PW-1:0]       win_idx, win_idx_nxt;
    logic [PW-1:0]       rr_ptr, rr_ptr_nxt;
    logic [BW-1:0]       burst_cnt, burst_cnt_nxt;
    logic                cmd_we, cmd_we_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt, ack_nxt;
    num                  rdata_nxt;
    logic [AW-1:0]       addr_nxt;
    num                  wdata_nxt;
    logic                read_nxt, write_nxt;

    logic [NUM_REQ-1:0]  pick_gnt_c;
    logic [PW-1:0]       pick_idx_c;
    logic                pick_any_c;

    logic [PW-1:0]       ld_idx;
    logic [AW-1:0]       ld_addr;
    num                  ld_wdata;
    logic                ld_we;
    logic                strobe;
    logic                burst_more;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .gnt_c (pick_gnt_c),
        .idx_c (pick_idx_c),
        .any_c (pick_any_c)
    );

    // Command source: fresh winner from IDLE, current owner on burst continuation
    assign ld_idx   = (state == ARB_IDLE) ? pick_idx_c : win_idx;
    assign ld_addr  = req_addr[ld_idx*AW +: AW];
    assign ld_wdata = req_wdata[ld_idx*NUM_W +: NUM_W];
    assign ld_we    = req_we[ld_idx];

    // A done coinciding with our own strobe belongs to nothing we issued
    assign strobe     = sram_read | sram_write;
    assign burst_more = req_lock[win_idx] && req[win_idx] && (burst_cnt < BURST_LAST);

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state;
        win_idx_nxt   = win_idx;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        cmd_we_nxt    = cmd_we;
        gnt_nxt       = gnt;
        ack_nxt       = '0;
        rdata_nxt     = rdata;
        addr_nxt      = sram_addr;
        wdata_nxt     = sram_wdata;
        read_nxt      = 1'b0;
        write_nxt     = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (pick_any_c) begin
                    gnt_nxt     = pick_gnt_c;
                    win_idx_nxt = pick_idx_c;
                    addr_nxt    = ld_addr;
                    wdata_nxt   = ld_wdata;
                    cmd_we_nxt  = ld_we;
                    state_nxt   = ARB_ISSUE;
                end
            end

            ARB_ISSUE: begin
                if (sram_ready) begin
                    read_nxt  = !cmd_we;
                    write_nxt = cmd_we;
                    state_nxt = ARB_WAIT;
                end
            end

            ARB_WAIT: begin
                if (sram_done && !strobe) begin
                    ack_nxt    = gnt;
                    rr_ptr_nxt = win_idx;
                    if (!cmd_we) begin
                        rdata_nxt = sram_rdata;
                    end
                    if (burst_more) begin
                        burst_cnt_nxt = burst_cnt + 1'b1;
                        addr_nxt      = ld_addr;
                        wdata_nxt     = ld_wdata;
                        cmd_we_nxt    = ld_we;
                        state_nxt     = ARB_ISSUE;
                    end else begin
                        burst_cnt_nxt = '0;
                        gnt_nxt       = '0;
                        state_nxt     = ARB_IDLE;
                    end
                end
            end

            default: begin
                gnt_nxt       = '0;
                burst_cnt_nxt = '0;
                state_nxt     = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            win_idx    <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            cmd_we     <= 1'b0;
            gnt        <= '0;
            ack        <= '0;
            rdata      <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_read  <= 1'b0;
            sram_write <= 1'b0;
        end else begin
            state      <= state_nxt;
            win_idx    <= win_idx_nxt;
            rr_ptr     <= rr_ptr_nxt;
            burst_cnt  <= burst_cnt_nxt;
            cmd_we     <= cmd_we_nxt;
            gnt        <= gnt_nxt;
            ack        <= ack_nxt;
            rdata      <= rdata_nxt;
            sram_addr  <= addr_nxt;
            sram_wdata <= wdata_nxt;
            sram_read  <= read_nxt;
            sram_write <= write_nxt;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: single read, write, locked burst, ready
// stall, spurious done, reset while waiting, and three-way contention.
module tb_sram_arbiter;
    import p3p_pkg::*;

    localparam int unsigned NR  = 3;
    localparam int unsigned AWB = 21;
    localparam int unsigned MB  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req, req_we, req_lock;
    logic [NR*AWB-1:0] req_addr;
    logic [NR*16-1:0]  req_wdata;
    logic [NR-1:0]     gnt, ack;
    num                rdata;
    logic              sram_ready;
    logic              sram_done = 1'b0;
    num                sram_rdata = '0;
    logic [AWB-1:0]    sram_addr;
    num                sram_wdata;
    logic              sram_read, sram_write;

    always #5 clk = ~clk;

    sram_arbiter #(
        .NUM_REQ   (NR),
        .AW        (AWB),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_we     (req_we),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .ack        (ack),
        .rdata      (rdata),
        .sram_ready (sram_ready),
        .sram_done  (sram_done),
        .sram_rdata (sram_rdata),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_read  (sram_read),
        .sram_write (sram_write)
    );

    // Controller model: done pulse lat cycles after the strobe cycle
    int unsigned lat = 3;
    num          ctl_data = '0;
    int unsigned inject_req = 0;
    int unsigned inject_seen = 0;
    int unsigned ctl_cnt = 0;

    always @(negedge clk) begin
        sram_done = 1'b0;
        if (ctl_cnt != 0) begin
            ctl_cnt--;
            if (ctl_cnt == 0) begin
                sram_done  = 1'b1;
                sram_rdata = ctl_data;
            end
        end
        if (inject_req != inject_seen) begin
            sram_done   = 1'b1;
            inject_seen = inject_req;
        end
        if (sram_read || sram_write) ctl_cnt = lat;
    end

    typedef struct {
        int unsigned    idx;
        logic           we;
        logic [AWB-1:0] addr;
        num             wdata;
        int unsigned    cyc;
    } strobe_t;

    strobe_t     sq[$];
    int unsigned ack_cyc[$];
    int unsigned cyc = 0;
    int unsigned ack_total = 0;
    int unsigned viol_gnt = 0, viol_ack = 0, viol_strobe = 0, viol_order = 0;
    logic        outstanding = 1'b0;
    logic [NR-1:0] ack_prev = '0;
    logic        strobe_prev = 1'b0;

    function automatic int unsigned oh2idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return 99;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Protocol monitor: logs strobes/acks and counts rule violations
    always @(negedge clk) begin
        if ($countones(gnt) > 1) viol_gnt++;
        if ($countones(ack) > 1 || (ack & ack_prev) != '0) viol_ack++;
        if ((sram_read && sram_write) || ((sram_read || sram_write) && strobe_prev)) viol_strobe++;
        if (reset) begin
            outstanding = 1'b0;
        end else begin
            if (sram_read || sram_write) begin
                if (outstanding) viol_order++;
                outstanding = 1'b1;
                sq.push_back('{idx: oh2idx(gnt), we: sram_write, addr: sram_addr,
                               wdata: sram_wdata, cyc: cyc});
            end
            if (ack != '0) begin
                outstanding = 1'b0;
                ack_total++;
                ack_cyc.push_back(cyc);
            end
        end
        ack_prev    = ack;
        strobe_prev = sram_read | sram_write;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int unsigned n, input int unsigned budget);
        int unsigned got;
        got = 0;
        for (int unsigned c = 0; c < budget && got < n; c++) begin
            tick();
            if (ack != '0) got++;
        end
        check("serve_acks", got, n);
    endtask

    task automatic set_cmd(input int i, input logic we, input logic [AWB-1:0] a, input logic [15:0] d);
        req_we[i]            = we;
        req_addr[i*AWB +: AWB] = a;
        req_wdata[i*16 +: 16]  = d;
    endtask

    int unsigned exp_burst[6] = '{0, 0, 0, 0, 2, 0};
    int unsigned exp_rr[6]    = '{1, 2, 0, 1, 2, 0};
    int unsigned nsq, nak, base;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_we     = '0;
        req_lock   = '0;
        req_addr   = '0;
        req_wdata  = '0;
        sram_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_rdata", $unsigned(rdata), 0);
        check("rst_addr", sram_addr, 0);
        check("rst_wdata", $unsigned(sram_wdata), 0);
        check("rst_read", sram_read, 0);
        check("rst_write", sram_write, 0);
        reset = 1'b0;
        tick();

        // Single read from requester 1, done 3 cycles after strobe
        set_cmd(1, 1'b0, 21'h10, 16'h0);
        ctl_data = 16'h1234;
        lat      = 3;
        req[1]   = 1'b1;
        tick();
        check("rd_gnt", gnt, 3'b010);
        check("rd_no_early_strobe", sram_read, 0);
        tick();
        check("rd_strobe", sram_read, 1);
        check("rd_addr", sram_addr, 32'h10);
        check("rd_no_write", sram_write, 0);
        tick();
        check("rd_strobe_1cyc", sram_read, 0);
        tick();
        tick();
        check("rd_ack_not_yet", ack, 0);
        tick();
        check("rd_ack", ack, 3'b010);
        check("rd_rdata", $unsigned(rdata), 32'h1234);
        check("rd_gnt_release", gnt, 0);
        req[1] = 1'b0;
        tick();
        check("rd_ack_pulse", ack, 0);
        check("rd_idle", gnt, 0);

        // Write from requester 2 at top address, rdata must not change
        ctl_data = 16'hBEEF;
        set_cmd(2, 1'b1, 21'h1FFFFF, 16'hFFFF);
        req[2] = 1'b1;
        serve(1, 50);
        req[2] = 1'b0;
        check("wr_ack", ack, 3'b100);
        check("wr_idx", sq[sq.size()-1].idx, 2);
        check("wr_we", sq[sq.size()-1].we, 1);
        check("wr_addr", sq[sq.size()-1].addr, 32'h1FFFFF);
        check("wr_wdata", $unsigned(sq[sq.size()-1].wdata), 32'hFFFF);
        check("wr_rdata_kept", $unsigned(rdata), 32'h1234);
        tick();

        // Locked burst of requester 0 against requester 2 (rr_ptr is 2 here)
        ctl_data = 16'h0BB0;
        lat      = 2;
        set_cmd(0, 1'b0, 21'h200, 16'h0);
        set_cmd(2, 1'b0, 21'h300, 16'h0);
        req_lock[0] = 1'b1;
        nsq = sq.size();
        nak = ack_cyc.size();
        req = 3'b101;
        serve(5, 300);
        req_lock[0] = 1'b0;
        serve(1, 100);
        req = '0;
        check("burst_count", sq.size() - nsq, 6);
        for (int k = 0; k < 6; k++) begin
            if (nsq + k < sq.size()) check($sformatf("burst_order%0d", k), sq[nsq+k].idx, exp_burst[k]);
        end
        if (nsq + 1 < sq.size() && nak < ack_cyc.size())
            check("burst_ack_to_strobe", sq[nsq+1].cyc - ack_cyc[nak], 1);
        check("burst_rdata", $unsigned(rdata), 32'h0BB0);
        tick();

        // Ready stall in ISSUE (rr_ptr is 0, requester 1 wins)
        sram_ready = 1'b0;
        set_cmd(1, 1'b0, 21'h55, 16'h0);
        ctl_data = 16'h0A0A;
        lat      = 3;
        nsq      = sq.size();
        req[1]   = 1'b1;
        tick();
        check("stall_gnt", gnt, 3'b010);
        repeat (10) tick();
        check("stall_no_strobe", sq.size() - nsq, 0);
        check("stall_gnt_held", gnt, 3'b010);
        sram_ready = 1'b1;
        serve(1, 50);
        req[1] = 1'b0;
        check("stall_one_strobe", sq.size() - nsq, 1);
        check("stall_addr", sq[sq.size()-1].addr, 32'h55);
        check("stall_rdata", $unsigned(rdata), 32'h0A0A);
        tick();

        // Spurious done while idle
        nak = ack_total;
        nsq = sq.size();
        inject_req++;
        repeat (4) tick();
        check("spur_no_ack", ack_total - nak, 0);
        check("spur_no_strobe", sq.size() - nsq, 0);
        check("spur_rdata", $unsigned(rdata), 32'h0A0A);

        // Reset while in WAIT (rr_ptr is 1, requester 2 wins)
        lat = 8;
        set_cmd(2, 1'b0, 21'h77, 16'h0);
        req[2] = 1'b1;
        tick();
        check("rstw_gnt", gnt, 3'b100);
        tick();
        check("rstw_strobe", sram_read, 1);
        tick();
        reset = 1'b1;
        #1;
        check("rstw_gnt0", gnt, 0);
        check("rstw_ack0", ack, 0);
        check("rstw_read0", sram_read, 0);
        check("rstw_addr0", sram_addr, 0);
        check("rstw_rdata0", $unsigned(rdata), 0);
        req = '0;
        tick();
        reset = 1'b0;
        nak = ack_total;
        repeat (10) tick();
        check("rstw_late_done_ignored", ack_total - nak, 0);
        check("rstw_idle", gnt, 0);

        // Contention after reset: order starts at rr_ptr+1 = 1
        for (int i = 0; i < NR; i++) set_cmd(i, 1'b0, AWB'(32'h100 + i), 16'h0);
        ctl_data = 16'h5A5A;
        lat      = 2;
        nsq      = sq.size();
        req      = 3'b111;
        serve(6, 400);
        req = '0;
        check("rr_count", sq.size() - nsq, 6);
        for (int k = 0; k < 6; k++) begin
            if (nsq + k < sq.size()) begin
                check($sformatf("rr_order%0d", k), sq[nsq+k].idx, exp_rr[k]);
                check($sformatf("rr_addr%0d", k), sq[nsq+k].addr, 32'h100 + exp_rr[k]);
            end
        end
        base = sq.size();
        repeat (5) tick();
        check("rr_quiet", sq.size() - base, 0);
        check("rr_rdata", $unsigned(rdata), 32'h5A5A);

        check("gnt_onehot", viol_gnt, 0);
        check("ack_single_pulse", viol_ack, 0);
        check("strobe_single", viol_strobe, 0);
        check("ack_before_strobe", viol_order, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
